// File: rtl/rf_pkg.sv
// Shared register-file definitions for the write-back arbiter, register file and pipeline stages.
package rf_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned NREG      = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREG);
  localparam int unsigned PEND_W    = 2;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_scoreboard.sv
// Per-register pending-write counters with reservation, RAW lookup and optional forwarding.
// Forwarding outputs exist only when RF_ARB_BYPASS_EN is defined.
module rf_write_arbiter_scoreboard #(
  parameter int unsigned XLEN   = rf_pkg::XLEN,
  parameter int unsigned NREG   = rf_pkg::NREG,
  parameter int unsigned PEND_W = rf_pkg::PEND_W,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             res_valid,
  input  logic [IDX_W-1:0] res_rd,
  output logic             res_ready,
  input  logic [IDX_W-1:0] rs1_idx,
  input  logic [IDX_W-1:0] rs2_idx,
  output logic             rs1_busy,
  output logic             rs2_busy,
`ifdef RF_ARB_BYPASS_EN
  input  logic [XLEN-1:0]  commit_data,
  output logic             rs1_fwd_hit,
  output logic             rs2_fwd_hit,
  output logic [XLEN-1:0]  rs1_fwd_data,
  output logic [XLEN-1:0]  rs2_fwd_data,
`endif
  input  logic             commit_we,
  input  logic [IDX_W-1:0] commit_rd
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] pend_cnt [NREG];
  logic [NREG-1:0]   inc_vec;
  logic [NREG-1:0]   dec_vec;
  logic              inc_en;
  logic              dec_en;

  // Entry 0 is held at zero, so x0 reservations are always accepted and never busy.
  assign res_ready = pend_cnt[res_rd] != CNT_MAX;
  assign inc_en    = res_valid && res_ready && (res_rd != '0);
  assign dec_en    = commit_we && (commit_rd != '0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc_en) inc_vec[res_rd] = 1'b1;
    if (dec_en) dec_vec[commit_rd] = 1'b1;
  end

  // A matching increment and decrement cancel; decrementing an empty counter is dropped.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset || flush || (r == 0)) begin
        pend_cnt[r] <= '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        pend_cnt[r] <= pend_cnt[r] + PEND_W'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (pend_cnt[r] != '0)) begin
        pend_cnt[r] <= pend_cnt[r] - PEND_W'(1);
      end
    end
  end

`ifdef RF_ARB_BYPASS_EN
  // The last outstanding write is on the port now, so decode may take it directly.
  assign rs1_fwd_hit  = commit_we && (commit_rd == rs1_idx) && (rs1_idx != '0) &&
                        (pend_cnt[rs1_idx] == PEND_W'(1));
  assign rs2_fwd_hit  = commit_we && (commit_rd == rs2_idx) && (rs2_idx != '0) &&
                        (pend_cnt[rs2_idx] == PEND_W'(1));
  assign rs1_fwd_data = commit_data;
  assign rs2_fwd_data = commit_data;
  assign rs1_busy     = (pend_cnt[rs1_idx] != '0) && !rs1_fwd_hit;
  assign rs2_busy     = (pend_cnt[rs2_idx] != '0) && !rs2_fwd_hit;
`else
  assign rs1_busy = pend_cnt[rs1_idx] != '0;
  assign rs2_busy = pend_cnt[rs2_idx] != '0;
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load unit.
// Optional RF_ARB_BYPASS_EN adds write-port forwarding to the hazard lookup.
module rf_write_arbiter #(
  parameter int unsigned XLEN   = rf_pkg::XLEN,
  parameter int unsigned NREG   = rf_pkg::NREG,
  parameter int unsigned PEND_W = rf_pkg::PEND_W,
  localparam int unsigned IDX_W = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][IDX_W-1:0] req_rd,
  input  logic [1:0][XLEN-1:0]  req_data,
  input  logic                  res_valid,
  input  logic [IDX_W-1:0]      res_rd,
  output logic                  res_ready,
  input  logic [IDX_W-1:0]      rs1_idx,
  input  logic [IDX_W-1:0]      rs2_idx,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
`ifdef RF_ARB_BYPASS_EN
  output logic                  rs1_fwd_hit,
  output logic                  rs2_fwd_hit,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data,
`endif
  output logic                  rf_we,
  output logic [IDX_W-1:0]      rf_rd,
  output logic [XLEN-1:0]       rf_wdata
);

  import rf_pkg::*;

  logic       last_grant;
  logic [1:0] grant;
  logic       xfer;
  logic       win_sel;
  rf_wr_req_t win;

  // Lone requester always wins; on a tie the one not granted last time wins.
  always_comb begin
    grant = 2'b00;
    unique case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign win_sel   = grant[1];

  always_comb begin
    win.rd   = req_rd[win_sel];
    win.data = req_data[win_sel];
  end

  // x0 writes complete the handshake but never raise rf_we.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
    end else begin
      rf_we <= 1'b0;
      if (xfer) begin
        last_grant <= win_sel;
        rf_we      <= win.rd != '0;
        rf_rd      <= win.rd;
        rf_wdata   <= win.data;
      end
    end
  end

  rf_write_arbiter_scoreboard #(
    .XLEN   (XLEN),
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .res_valid    (res_valid),
    .res_rd       (res_rd),
    .res_ready    (res_ready),
    .rs1_idx      (rs1_idx),
    .rs2_idx      (rs2_idx),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
`ifdef RF_ARB_BYPASS_EN
    .commit_data  (rf_wdata),
    .rs1_fwd_hit  (rs1_fwd_hit),
    .rs2_fwd_hit  (rs2_fwd_hit),
    .rs1_fwd_data (rs1_fwd_data),
    .rs2_fwd_data (rs2_fwd_data),
`endif
    .commit_we    (rf_we),
    .commit_rd    (rf_rd)
  );

endmodule
